// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: FSM encodings and sizing defaults.
package hazard_ctrl_pkg;
   localparam int RF_AW_DEF = 5;
   localparam int CNT_W     = 4;   // holds MAX_OUTSTANDING up to 15

   typedef enum logic [1:0] {
      HZ_RUN   = 2'd0,
      HZ_HAZ   = 2'd1,
      HZ_FLUSH = 2'd2
   } hz_state_t;
endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard and outstanding-op counter for
// long-latency writes. x0 is never tracked.
module hazard_scoreboard
   import hazard_ctrl_pkg::*;
#(
   parameter int RF_AW           = RF_AW_DEF,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   set_en,
   input  logic [RF_AW-1:0]       set_addr,
   input  logic                   clr_en,
   input  logic [RF_AW-1:0]       clr_addr,
   output logic [(1<<RF_AW)-1:0]  sb,
   output logic [CNT_W-1:0]       cnt
);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   logic                  do_set, do_clr;
   logic [(1<<RF_AW)-1:0] sb_nxt;

   // Saturation guard keeps cnt bounded even if a caller ignores the full term.
   assign do_set = set_en && (set_addr != '0) && (cnt != MAX_CNT);
   assign do_clr = clr_en && (clr_addr != '0) && sb[clr_addr];

   always_comb begin
      sb_nxt = sb;
      if (do_clr) sb_nxt[clr_addr] = 1'b0;
      if (do_set) sb_nxt[set_addr] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sb  <= '0;
         cnt <= '0;
      end else begin
         sb <= sb_nxt;
         case ({do_set, do_clr})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end
endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage sequencing controller: hazard detection, stall/flush priority and
// RUN/HAZ/FLUSH FSM. Optional perf counters under CORE_HAZARD_PERF_EN.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int RF_AW           = RF_AW_DEF,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [RF_AW-1:0] id_rs1_addr,
   input  logic             id_rs1_use,
   input  logic [RF_AW-1:0] id_rs2_addr,
   input  logic             id_rs2_use,
   input  logic [RF_AW-1:0] id_rd_addr,
   input  logic             id_rd_wen,
   input  logic             id_long_lat,
   input  logic             id_fence,
   input  logic             ex_branch_taken,
   input  logic             mem_stall,
   input  logic             lat_done,
   input  logic [RF_AW-1:0] lat_waddr,
   output logic             if_stall,
   output logic             if_flush,
   output logic             id2ex_bubble,
   output logic             id_issue,
   output logic             sb_empty
`ifdef CORE_HAZARD_PERF_EN
  ,output logic [31:0]      stall_cycles,
   output logic [31:0]      flush_count
`endif
);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   hz_state_t             state, state_nxt;
   logic [(1<<RF_AW)-1:0] sb;
   logic [CNT_W-1:0]      cnt;
   logic                  valid, raw, waw, full, fnc, hazard;

   hazard_scoreboard #(.RF_AW(RF_AW), .MAX_OUTSTANDING(MAX_OUTSTANDING)) u_sb (
      .clk      (clk),
      .rst      (rst),
      .set_en   (id_issue && id_rd_wen && id_long_lat),
      .set_addr (id_rd_addr),
      .clr_en   (lat_done),
      .clr_addr (lat_waddr),
      .sb       (sb),
      .cnt      (cnt)
   );

   // The slot behind a redirect holds a wrong-path fetch, so it never counts as valid.
   assign valid  = id_valid && (state != HZ_FLUSH);
   assign raw    = (id_rs1_use && sb[id_rs1_addr]) || (id_rs2_use && sb[id_rs2_addr]);
   assign waw    = id_rd_wen && sb[id_rd_addr];
   assign full   = id_long_lat && (cnt == MAX_CNT);
   assign fnc    = id_fence && (cnt != '0);
   assign hazard = valid && (raw || waw || full || fnc);
   assign sb_empty = (cnt == '0);

   always_comb begin
      if_stall     = 1'b0;
      if_flush     = 1'b0;
      id2ex_bubble = 1'b0;
      id_issue     = 1'b0;
      state_nxt    = HZ_RUN;
      // Controls are quiet while reset is held so nothing moves during reset.
      if (rst) begin
         if (ex_branch_taken) begin
            if_flush     = 1'b1;
            id2ex_bubble = 1'b1;
         end else if (mem_stall) begin
            if_stall     = 1'b1;
         end else if (hazard) begin
            if_stall     = 1'b1;
            id2ex_bubble = 1'b1;
         end else begin
            id_issue     = valid;
            id2ex_bubble = !valid;
         end
         if (ex_branch_taken) state_nxt = HZ_FLUSH;
         else if (hazard)     state_nxt = HZ_HAZ;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= HZ_RUN;
      else      state <= state_nxt;
   end

`ifdef CORE_HAZARD_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (if_stall)        stall_cycles <= stall_cycles + 32'd1;
         if (ex_branch_taken) flush_count  <= flush_count + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl against a cycle-level scoreboard model.
module tb_hazard_ctrl;
   localparam int MAXO = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       id_valid = 0, id_rs1_use = 0, id_rs2_use = 0, id_rd_wen = 0;
   logic       id_long_lat = 0, id_fence = 0, ex_branch_taken = 0, mem_stall = 0, lat_done = 0;
   logic [4:0] id_rs1_addr = 0, id_rs2_addr = 0, id_rd_addr = 0, lat_waddr = 0;
   logic       if_stall, if_flush, id2ex_bubble, id_issue, sb_empty;
`ifdef CORE_HAZARD_PERF_EN
   logic [31:0] stall_cycles, flush_count;
   int unsigned m_stalls = 0, m_flushes = 0;
`endif

   int checks = 0, failures = 0;

   // reference state: pending registers, outstanding count, redirect shadow
   bit sb_m [32];
   int cnt_m = 0;
   bit shadow_m = 0;

   hazard_ctrl #(.RF_AW(5), .MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs1_addr(id_rs1_addr), .id_rs1_use(id_rs1_use),
      .id_rs2_addr(id_rs2_addr), .id_rs2_use(id_rs2_use),
      .id_rd_addr(id_rd_addr), .id_rd_wen(id_rd_wen),
      .id_long_lat(id_long_lat), .id_fence(id_fence),
      .ex_branch_taken(ex_branch_taken), .mem_stall(mem_stall),
      .lat_done(lat_done), .lat_waddr(lat_waddr),
      .if_stall(if_stall), .if_flush(if_flush), .id2ex_bubble(id2ex_bubble),
      .id_issue(id_issue), .sb_empty(sb_empty)
`ifdef CORE_HAZARD_PERF_EN
     ,.stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      foreach (sb_m[i]) sb_m[i] = 0;
      cnt_m = 0;
      shadow_m = 0;
`ifdef CORE_HAZARD_PERF_EN
      m_stalls = 0;
      m_flushes = 0;
`endif
   endtask

   // Called just after a negedge with inputs already driven; checks, then
   // advances the model to what the coming posedge should produce.
   task automatic step();
      bit v, hz, e_st, e_fl, e_bb, e_is;
      #1;
      v  = id_valid && !shadow_m;
      hz = v && ((id_rs1_use && sb_m[id_rs1_addr]) || (id_rs2_use && sb_m[id_rs2_addr]) ||
                 (id_rd_wen && sb_m[id_rd_addr]) || (id_long_lat && cnt_m == MAXO) ||
                 (id_fence && cnt_m != 0));
      e_st = 0; e_fl = 0; e_bb = 0; e_is = 0;
      if (!rst) begin
         model_reset();
      end else begin
         if (ex_branch_taken)  begin e_fl = 1; e_bb = 1; end
         else if (mem_stall)   e_st = 1;
         else if (hz)          begin e_st = 1; e_bb = 1; end
         else                  begin e_is = v; e_bb = !v; end
      end
      chk("if_stall", if_stall, e_st);
      chk("if_flush", if_flush, e_fl);
      chk("id2ex_bubble", id2ex_bubble, e_bb);
      chk("id_issue", id_issue, e_is);
      chk("sb_empty", sb_empty, cnt_m == 0);
`ifdef CORE_HAZARD_PERF_EN
      chk("stall_cycles", stall_cycles, m_stalls);
      chk("flush_count", flush_count, m_flushes);
`endif
      if (rst) begin
         if (lat_done && lat_waddr != 0 && sb_m[lat_waddr]) begin
            sb_m[lat_waddr] = 0;
            cnt_m--;
         end
         if (e_is && id_rd_wen && id_long_lat && id_rd_addr != 0) begin
            sb_m[id_rd_addr] = 1;
            cnt_m++;
         end
         shadow_m = ex_branch_taken;
`ifdef CORE_HAZARD_PERF_EN
         if (e_st) m_stalls++;
         if (ex_branch_taken) m_flushes++;
`endif
      end
      @(negedge clk);
   endtask

   task automatic idle();
      id_valid = 0; id_rs1_use = 0; id_rs2_use = 0; id_rd_wen = 0;
      id_long_lat = 0; id_fence = 0; ex_branch_taken = 0; mem_stall = 0; lat_done = 0;
      id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; lat_waddr = 0;
   endtask

   task automatic rand_in();
      id_valid        = ($urandom_range(0, 9) < 8);
      id_rs1_use      = $urandom_range(0, 1);
      id_rs2_use      = $urandom_range(0, 1);
      id_rd_wen       = ($urandom_range(0, 3) != 0);
      id_long_lat     = ($urandom_range(0, 2) != 0);
      id_fence        = ($urandom_range(0, 19) == 0);
      ex_branch_taken = ($urandom_range(0, 11) == 0);
      mem_stall       = ($urandom_range(0, 7) == 0);
      lat_done        = ($urandom_range(0, 3) == 0);
      id_rs1_addr     = 5'($urandom_range(0, 9));
      id_rs2_addr     = 5'($urandom_range(0, 9));
      id_rd_addr      = 5'($urandom_range(0, 9));
      lat_waddr       = 5'($urandom_range(0, 9));
   endtask

   initial begin
      model_reset();
      idle();
      @(negedge clk);
      step();                       // reset values with idle inputs
      rst = 1;
      step();

      // load x7, dependent read stalls, then async reset mid-stall
      id_valid = 1; id_rd_wen = 1; id_long_lat = 1; id_rd_addr = 7;
      step();
      idle(); id_valid = 1; id_rs1_use = 1; id_rs1_addr = 7;
      step();
      step();
      #3 rst = 0;
      #1 chk("async_rst_empty", sb_empty, 1'b1);
      chk("async_rst_stall", if_stall, 1'b0);
      @(negedge clk);
      idle(); lat_done = 1; lat_waddr = 7;
      step();                       // late completion while in reset
      rst = 1;
      step();                       // late completion after reset: ignored
      idle(); id_valid = 1; id_rs1_use = 1; id_rs1_addr = 7;
      step();

      // fence drains two outstanding ops; stray completions on x0 and x9 ignored
      idle(); id_valid = 1; id_rd_wen = 1; id_long_lat = 1; id_rd_addr = 1;
      step();
      id_rd_addr = 2;
      step();
      idle(); id_valid = 1; id_fence = 1; lat_done = 1; lat_waddr = 0;
      step();
      lat_waddr = 9;
      step();
      lat_waddr = 1;
      step();
      lat_waddr = 2;
      step();
      idle(); id_valid = 1; id_fence = 1;
      step();

      for (int i = 0; i < 3000; i++) begin
         rand_in();
         step();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
